// File: rtl/cc_attach_detector_if.sv
// USB-C CC attach detector port bundle: raw CC levels in, debounced status out.
// Latency: none, wires only.
// Backpressure: none; status outputs are level/pulse signals with no handshake.
interface cc_attach_detector_if;
  logic       CC1;
  logic       CC2;
  logic       attached;
  logic       orient;
  logic [1:0] cc_state;
  logic       attach_evt;
  logic       detach_evt;
`ifdef CC_EVENT_IRQ_EN
  logic       cc_irq_clr;
  logic       cc_irq;

  modport master (
    output CC1, CC2, cc_irq_clr,
    input  attached, orient, cc_state, attach_evt, detach_evt, cc_irq
  );
  modport slave (
    input  CC1, CC2, cc_irq_clr,
    output attached, orient, cc_state, attach_evt, detach_evt, cc_irq
  );
`else
  modport master (
    output CC1, CC2,
    input  attached, orient, cc_state, attach_evt, detach_evt
  );
  modport slave (
    input  CC1, CC2,
    output attached, orient, cc_state, attach_evt, detach_evt
  );
`endif
endinterface

// File: rtl/cc_attach_detector.sv
// USB-C CC attach/detach debouncer with orientation detect; optional sticky IRQ under CC_EVENT_IRQ_EN.
// Latency: attached rises 3+DEBOUNCE_CYC edges after CC levels settle (2 sync + entry + debounce).
// Backpressure: none; events are single-cycle registered pulses, cc_irq holds until cleared.
module cc_attach_detector #(
  parameter int unsigned DEBOUNCE_CYC = 4
) (
  input logic             clk,
  input logic             reset,
  cc_attach_detector_if.slave bus
);

  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYC - 1);

  typedef enum logic [1:0] {
    ST_UNATTACHED  = 2'd0,
    ST_ATTACH_WAIT = 2'd1,
    ST_ATTACHED    = 2'd2,
    ST_DETACH_WAIT = 2'd3
  } state_t;

  logic   cc1_meta, cc2_meta;
  logic   s1, s2;
  state_t state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic   cand, cand_nxt;
  logic   attached_q, attached_nxt;
  logic   orient_q, orient_nxt;
  logic   attach_evt_q, attach_evt_nxt;
  logic   detach_evt_q, detach_evt_nxt;
  logic   pat_vld;
  logic   pat_match;

  // Two-flop synchronizers for the asynchronous CC levels.
  always_ff @(posedge clk) begin
    if (reset) begin
      cc1_meta <= 1'b0;
      cc2_meta <= 1'b0;
      s1       <= 1'b0;
      s2       <= 1'b0;
    end else begin
      cc1_meta <= bus.CC1;
      cc2_meta <= bus.CC2;
      s1       <= cc1_meta;
      s2       <= cc2_meta;
    end
  end

  // Exactly one CC line terminated is a usable pattern; open and both-high are not.
  assign pat_vld   = s1 ^ s2;
  assign pat_match = pat_vld && (s2 == cand);

  // State, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_UNATTACHED;
      cnt          <= 8'd0;
      cand         <= 1'b0;
      attached_q   <= 1'b0;
      orient_q     <= 1'b0;
      attach_evt_q <= 1'b0;
      detach_evt_q <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      cand         <= cand_nxt;
      attached_q   <= attached_nxt;
      orient_q     <= orient_nxt;
      attach_evt_q <= attach_evt_nxt;
      detach_evt_q <= detach_evt_nxt;
    end
  end

  // Next-state logic: the counter exits at CNT_LAST so it can never wrap.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    cand_nxt       = cand;
    attached_nxt   = attached_q;
    orient_nxt     = orient_q;
    attach_evt_nxt = 1'b0;
    detach_evt_nxt = 1'b0;
    unique case (state)
      ST_UNATTACHED: begin
        if (pat_vld) begin
          state_nxt = ST_ATTACH_WAIT;
          cnt_nxt   = 8'd0;
          cand_nxt  = s2;
        end
      end
      ST_ATTACH_WAIT: begin
        if (!pat_match) begin
          state_nxt = ST_UNATTACHED;
        end else if (cnt == CNT_LAST) begin
          state_nxt      = ST_ATTACHED;
          attached_nxt   = 1'b1;
          orient_nxt     = cand;
          attach_evt_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      ST_ATTACHED: begin
        // Any change, including a swap, must go through a full detach first.
        if (!pat_match) begin
          state_nxt = ST_DETACH_WAIT;
          cnt_nxt   = 8'd0;
        end
      end
      ST_DETACH_WAIT: begin
        if (pat_match) begin
          state_nxt = ST_ATTACHED;
        end else if (cnt == CNT_LAST) begin
          state_nxt      = ST_UNATTACHED;
          attached_nxt   = 1'b0;
          detach_evt_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      default: state_nxt = ST_UNATTACHED;
    endcase
  end

  assign bus.attached   = attached_q;
  assign bus.orient     = orient_q;
  assign bus.cc_state   = state;
  assign bus.attach_evt = attach_evt_q;
  assign bus.detach_evt = detach_evt_q;

`ifdef CC_EVENT_IRQ_EN
  logic irq_q;

  // Sticky interrupt: an event arriving with a clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q <= 1'b0;
    end else if (attach_evt_q || detach_evt_q) begin
      irq_q <= 1'b1;
    end else if (bus.cc_irq_clr) begin
      irq_q <= 1'b0;
    end
  end

  assign bus.cc_irq = irq_q;
`endif

endmodule

// File: tb/tb_cc_attach_detector.sv
// Self-checking bench for cc_attach_detector against a run-length reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_cc_attach_detector;

  localparam int D = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic irq_clr = 1'b0;
  int   cmp_cnt = 0;
  int   err_cnt = 0;

  always #5 clk = ~clk;

  cc_attach_detector_if bus();
`ifdef CC_EVENT_IRQ_EN
  assign bus.cc_irq_clr = irq_clr;
`endif

  cc_attach_detector #(.DEBOUNCE_CYC(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Reference model: raw samples delayed two edges, then consecutive-sample run lengths.
  bit d1a, d1b, d2a, d2b;
  bit m_att, m_orient, m_cand, m_aevt, m_devt, m_irq;
  int m_run;

  task automatic model_edge(input bit a, input bit b, input bit r);
    bit sa, sb, valid, match;
    if (r) begin
      d1a = 0; d1b = 0; d2a = 0; d2b = 0;
      m_att = 0; m_orient = 0; m_cand = 0; m_run = 0;
      m_aevt = 0; m_devt = 0; m_irq = 0;
      return;
    end
    if (m_aevt || m_devt) m_irq = 1;
    else if (irq_clr)     m_irq = 0;
    sa = d2a; sb = d2b;
    d2a = d1a; d2b = d1b; d1a = a; d1b = b;
    valid = sa ^ sb;
    match = valid && (sb == m_cand);
    m_aevt = 0; m_devt = 0;
    if (!m_att) begin
      // Attach needs the first valid sample plus D more identical ones.
      if (m_run == 0) begin
        if (valid) begin m_cand = sb; m_run = 1; end
      end else if (match) begin
        m_run++;
        if (m_run == D + 1) begin
          m_att = 1; m_orient = m_cand; m_aevt = 1; m_run = 0;
        end
      end else begin
        m_run = 0;
      end
    end else begin
      // Detach needs D+1 consecutive samples that are not the attached pattern.
      if (match) m_run = 0;
      else begin
        m_run++;
        if (m_run == D + 1) begin
          m_att = 0; m_devt = 1; m_run = 0;
        end
      end
    end
  endtask

  function automatic logic [6:0] exp_vec();
    logic [1:0] st;
    if (!m_att) st = (m_run == 0) ? 2'd0 : 2'd1;
    else        st = (m_run == 0) ? 2'd2 : 2'd3;
`ifdef CC_EVENT_IRQ_EN
    return {m_att, m_orient, st, m_aevt, m_devt, m_irq};
`else
    return {m_att, m_orient, st, m_aevt, m_devt, 1'b0};
`endif
  endfunction

  function automatic logic [6:0] obs_vec();
`ifdef CC_EVENT_IRQ_EN
    return {bus.attached, bus.orient, bus.cc_state, bus.attach_evt, bus.detach_evt, bus.cc_irq};
`else
    return {bus.attached, bus.orient, bus.cc_state, bus.attach_evt, bus.detach_evt, 1'b0};
`endif
  endfunction

  // One clock: drive at negedge, model at posedge, return at the next negedge.
  task automatic step(input bit a, input bit b, input bit r);
    bus.CC1 = a; bus.CC2 = b; reset = r;
    @(posedge clk);
    model_edge(a, b, r);
    @(negedge clk);
  endtask

  task automatic do_reset();
    step(0, 0, 1);
    step(0, 0, 1);
  endtask

  task automatic test_reset();
    bus.CC1 = 1'b1; bus.CC2 = 1'b0;
    @(negedge clk);
    step(1, 0, 1);
    step(1, 0, 1);
    cmp_cnt++;
    if (obs_vec() !== 7'b0) begin
      err_cnt++;
      $display("FAIL reset_state: got %b want %b", obs_vec(), 7'b0);
    end
  endtask

  task automatic test_attach_cc1();
    int aevt_n = 0;
    do_reset();
    for (int e = 1; e <= 12; e++) begin
      step(1, 0, 0);
      if (bus.attach_evt === 1'b1) aevt_n++;
      cmp_cnt++;
      if (obs_vec() !== exp_vec()) begin
        err_cnt++;
        $display("FAIL attach_cc1 e%0d: got %b want %b", e, obs_vec(), exp_vec());
      end
      if (e == 2 || e == 3 || e == 2 + D || e == 3 + D) begin
        cmp_cnt++;
        if (bus.cc_state !== ((e == 2) ? 2'd0 : (e == 3 + D) ? 2'd2 : 2'd1) ||
            bus.attached !== (e == 3 + D) || bus.attach_evt !== (e == 3 + D)) begin
          err_cnt++;
          $display("FAIL attach_cc1_edge e%0d: state %0d att %b evt %b", e, bus.cc_state, bus.attached, bus.attach_evt);
        end
      end
    end
    cmp_cnt++;
    if (aevt_n != 1 || bus.orient !== 1'b0) begin
      err_cnt++;
      $display("FAIL attach_cc1_pulse: pulses %0d orient %b want 1 and 0", aevt_n, bus.orient);
    end
  endtask

  task automatic test_cc2_detach();
    do_reset();
    for (int e = 1; e <= 10; e++) begin
      step(0, 1, 0);
      cmp_cnt++;
      if (obs_vec() !== exp_vec()) begin
        err_cnt++;
        $display("FAIL cc2_attach e%0d: got %b want %b", e, obs_vec(), exp_vec());
      end
    end
    cmp_cnt++;
    if (bus.attached !== 1'b1 || bus.orient !== 1'b1) begin
      err_cnt++;
      $display("FAIL cc2_orient: att %b orient %b want 1 1", bus.attached, bus.orient);
    end
    for (int e = 1; e <= 10; e++) begin
      step(0, 0, 0);
      cmp_cnt++;
      if (obs_vec() !== exp_vec()) begin
        err_cnt++;
        $display("FAIL cc2_detach e%0d: got %b want %b", e, obs_vec(), exp_vec());
      end
      if (e == 2 + D || e == 3 + D) begin
        cmp_cnt++;
        if (bus.attached !== (e != 3 + D) || bus.detach_evt !== (e == 3 + D)) begin
          err_cnt++;
          $display("FAIL cc2_detach_edge e%0d: att %b devt %b", e, bus.attached, bus.detach_evt);
        end
      end
    end
    cmp_cnt++;
    if (bus.orient !== 1'b1) begin
      err_cnt++;
      $display("FAIL orient_hold: got %b want 1", bus.orient);
    end
  endtask

  task automatic test_glitch();
    int aevt_n = 0;
    do_reset();
    for (int e = 1; e <= 12; e++) begin
      step(e <= 2, 0, 0);
      if (bus.attach_evt === 1'b1) aevt_n++;
      cmp_cnt++;
      if (obs_vec() !== exp_vec()) begin
        err_cnt++;
        $display("FAIL glitch e%0d: got %b want %b", e, obs_vec(), exp_vec());
      end
    end
    cmp_cnt++;
    if (aevt_n != 0 || bus.attached !== 1'b0 || bus.cc_state !== 2'd0) begin
      err_cnt++;
      $display("FAIL glitch_end: pulses %0d att %b state %0d want 0 0 0", aevt_n, bus.attached, bus.cc_state);
    end
  endtask

  task automatic test_drop_return();
    int devt_n = 0;
    bit saw_dw = 0;
    bit att_low = 0;
    do_reset();
    for (int e = 1; e <= 10; e++) step(1, 0, 0);
    for (int e = 1; e <= 12; e++) begin
      step(!(e == 1 || e == 2), 0, 0);
      if (bus.detach_evt === 1'b1) devt_n++;
      if (bus.cc_state === 2'd3) saw_dw = 1;
      if (bus.attached !== 1'b1) att_low = 1;
      cmp_cnt++;
      if (obs_vec() !== exp_vec()) begin
        err_cnt++;
        $display("FAIL drop_return e%0d: got %b want %b", e, obs_vec(), exp_vec());
      end
    end
    cmp_cnt++;
    if (devt_n != 0 || !saw_dw || att_low || bus.cc_state !== 2'd2) begin
      err_cnt++;
      $display("FAIL drop_return_end: devt %0d saw_dw %b att_low %b state %0d", devt_n, saw_dw, att_low, bus.cc_state);
    end
  endtask

  task automatic test_both_high();
    bit bad = 0;
    do_reset();
    for (int e = 1; e <= 20; e++) begin
      step(1, 1, 0);
      if (bus.cc_state !== 2'd0 || bus.attach_evt !== 1'b0 || bus.detach_evt !== 1'b0) bad = 1;
      cmp_cnt++;
      if (obs_vec() !== exp_vec()) begin
        err_cnt++;
        $display("FAIL both_high e%0d: got %b want %b", e, obs_vec(), exp_vec());
      end
    end
    cmp_cnt++;
    if (bad) begin
      err_cnt++;
      $display("FAIL both_high_idle: left UNATTACHED or evented, got 1 want 0");
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int e = 1; e <= 4; e++) step(1, 0, 0);
    step(1, 0, 1);
    cmp_cnt++;
    if (obs_vec() !== 7'b0) begin
      err_cnt++;
      $display("FAIL reset_mid: got %b want %b", obs_vec(), 7'b0);
    end
    for (int e = 1; e <= 3 + D; e++) begin
      step(1, 0, 0);
      cmp_cnt++;
      if (obs_vec() !== exp_vec() || bus.attached !== (e == 3 + D)) begin
        err_cnt++;
        $display("FAIL reattach e%0d: got %b want %b", e, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_swap();
    int aevt_n = 0;
    int devt_n = 0;
    bit silent = 0;
    do_reset();
    for (int e = 1; e <= 10; e++) step(1, 0, 0);
    for (int e = 1; e <= 16; e++) begin
      step(0, 1, 0);
      if (bus.attach_evt === 1'b1) aevt_n++;
      if (bus.detach_evt === 1'b1) devt_n++;
      if (bus.attached === 1'b1 && bus.orient === 1'b1 && devt_n == 0) silent = 1;
      cmp_cnt++;
      if (obs_vec() !== exp_vec()) begin
        err_cnt++;
        $display("FAIL swap e%0d: got %b want %b", e, obs_vec(), exp_vec());
      end
    end
    cmp_cnt++;
    if (aevt_n != 1 || devt_n != 1 || silent || bus.orient !== 1'b1 || bus.attached !== 1'b1) begin
      err_cnt++;
      $display("FAIL swap_end: aevt %0d devt %0d silent %b orient %b att %b", aevt_n, devt_n, silent, bus.orient, bus.attached);
    end
  endtask

  task automatic test_random();
    bit a, b, r;
    int len;
    do_reset();
    for (int s = 0; s < 150; s++) begin
      a = 1'($urandom_range(0, 1));
      b = 1'($urandom_range(0, 1));
      r = ($urandom_range(0, 39) == 0);
      len = $urandom_range(1, 2 * D + 3);
      for (int c = 0; c < len; c++) begin
        irq_clr = ($urandom_range(0, 3) == 0);
        step(a, b, r && c == 0);
        cmp_cnt++;
        if (obs_vec() !== exp_vec() || (bus.attach_evt === 1'b1 && bus.detach_evt === 1'b1)) begin
          err_cnt++;
          $display("FAIL random s%0d c%0d: got %b want %b", s, c, obs_vec(), exp_vec());
        end
      end
    end
    irq_clr = 1'b0;
  endtask

`ifdef CC_EVENT_IRQ_EN
  task automatic test_irq();
    irq_clr = 1'b0;
    do_reset();
    for (int e = 1; e <= 10; e++) begin
      step(1, 0, 0);
      cmp_cnt++;
      if (bus.cc_irq !== (e >= 4 + D) || obs_vec() !== exp_vec()) begin
        err_cnt++;
        $display("FAIL irq_attach e%0d: irq %b vec %b want %b", e, bus.cc_irq, obs_vec(), exp_vec());
      end
    end
    irq_clr = 1'b1;
    step(1, 0, 0);
    irq_clr = 1'b0;
    cmp_cnt++;
    if (bus.cc_irq !== 1'b0) begin
      err_cnt++;
      $display("FAIL irq_clear: got %b want 0", bus.cc_irq);
    end
    for (int e = 1; e <= 10; e++) begin
      irq_clr = (e == 4 + D);
      step(0, 0, 0);
      cmp_cnt++;
      if (bus.cc_irq !== (e >= 4 + D) || obs_vec() !== exp_vec()) begin
        err_cnt++;
        $display("FAIL irq_set_wins e%0d: irq %b vec %b want %b", e, bus.cc_irq, obs_vec(), exp_vec());
      end
    end
    irq_clr = 1'b0;
  endtask
`endif

  initial begin
    bus.CC1 = 1'b0;
    bus.CC2 = 1'b0;
    test_reset();
    test_attach_cc1();
    test_cc2_detach();
    test_glitch();
    test_drop_return();
    test_both_high();
    test_reset_mid();
    test_swap();
`ifdef CC_EVENT_IRQ_EN
    test_irq();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/cc_attach_detector.md
CC_ATTACH_DETECTOR -- requirements
Module: cc_attach_detector

Interface
REQ-001 Parameter DEBOUNCE_CYC, default 4, consecutive stable cycles required to confirm attach or detach; legal range 1..255.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 CC1  input  1  raw CC1 termination-present level, asynchronous to clk.
REQ-005 CC2  input  1  raw CC2 termination-present level, asynchronous to clk.
REQ-006 attached  output  1  debounced attach status.
REQ-007 orient  output  1  0 = CC1 active, 1 = CC2 active (flipped plug).
REQ-008 cc_state  output  2  FSM state: 0 UNATTACHED, 1 ATTACH_WAIT, 2 ATTACHED, 3 DETACH_WAIT.
REQ-009 attach_evt  output  1  one-cycle pulse on confirmed attach.
REQ-010 detach_evt  output  1  one-cycle pulse on confirmed detach.

Function
REQ-011 CC1 and CC2 SHALL each pass through a 2-flop synchronizer; only synchronized values (s1, s2) feed the FSM.
REQ-012 Pattern valid SHALL mean exactly one of s1/s2 is high; both-low (open) and both-high (invalid) SHALL both be non-valid.
REQ-013 Candidate orientation SHALL be s2 (0 = CC1), latched on the UNATTACHED->ATTACH_WAIT transition.
REQ-014 UNATTACHED: valid pattern -> ATTACH_WAIT, counter cleared to 0; otherwise stay.
REQ-015 ATTACH_WAIT: pattern not valid or differs from candidate -> UNATTACHED, no event; else if counter == DEBOUNCE_CYC-1 -> ATTACHED, else counter increments.
REQ-016 On ATTACH_WAIT->ATTACHED, attached SHALL go 1, orient SHALL load candidate, attach_evt SHALL pulse high for exactly one cycle.
REQ-017 Attach latency: attached SHALL rise at rising edge 3+DEBOUNCE_CYC counted from the first edge sampling the new stable CC levels (edge 7 for default).
REQ-018 ATTACHED: pattern differs from candidate (including both-low, both-high, swapped) -> DETACH_WAIT, counter cleared.
REQ-019 DETACH_WAIT: pattern equals candidate again -> ATTACHED, no event, attached stays 1; else if counter == DEBOUNCE_CYC-1 -> UNATTACHED, else counter increments.
REQ-020 On DETACH_WAIT->UNATTACHED, attached SHALL go 0 and detach_evt SHALL pulse one cycle; orient SHALL hold its last value until next attach.
REQ-021 Direct swap CC1->CC2 while ATTACHED SHALL first complete a detach (detach_evt) then a fresh attach with orient=1; never a silent orient change.
REQ-022 Counter SHALL be 8 bits and never wrap: it only counts in WAIT states and exits at DEBOUNCE_CYC-1.
REQ-023 attach_evt and detach_evt SHALL never be high in the same cycle; both outputs registered.

Reset
REQ-024 While reset is high at a rising edge: synchronizers 0, state UNATTACHED, counter 0, attached 0, orient 0, attach_evt 0, detach_evt 0.
REQ-025 Reset mid-debounce or while ATTACHED SHALL override all transitions and emit no event; re-attach requires a full new debounce.

Configuration
REQ-026 Macro CC_EVENT_IRQ_EN: when defined, adds input cc_irq_clr (1) and output cc_irq (1).
REQ-027 With CC_EVENT_IRQ_EN: cc_irq sets on the cycle after attach_evt or detach_evt, clears on cc_irq_clr; simultaneous set and clear -> set wins; reset clears it.
REQ-028 Without CC_EVENT_IRQ_EN: ports and logic absent; all other behaviour identical.

Verification
REQ-029 Reset 2 cycles, CC1=1 CC2=0 held -> attached=1, orient=0, attach_evt single pulse at edge 7; cc_state 0->1->2.
REQ-030 CC1=0 CC2=1 held -> attached=1, orient=1 after 7 edges; then CC2=0 -> detach_evt pulse, attached=0 at edge 7 after change.
REQ-031 CC1=1 for 2 cycles then 0 (glitch) -> cc_state returns to 0, no attach_evt, attached stays 0.
REQ-032 Attached on CC1, CC1 drops 2 cycles then returns -> cc_state 2->3->2, no detach_evt, attached stays 1.
REQ-033 CC1=CC2=1 held 20 cycles -> cc_state stays 0, no events; reset asserted during ATTACH_WAIT -> all outputs 0, no event.
REQ-034 CC_EVENT_IRQ_EN defined: attach -> cc_irq=1 held; cc_irq_clr coincident with detach_evt-driven set -> cc_irq stays 1.
